mant_normalize_pipe: RTL and testbench

- Stage directly downstream of the 8-bit leading-zero counter.
- Consumes a mantissa, its biased exponent and the LZC result, left-normalises the mantissa and decrements the exponent.
- Two-stage registered pipeline with valid/ready backpressure, a zero detect, exponent-underflow clamping and a saturating underflow event counter.

---
 rtl/mant_normalize_pipe_if.sv | 36 +++
 rtl/mant_normalize_pipe.sv | 133 +++++++++++++
 tb/tb_mant_normalize_pipe.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mant_normalize_pipe_if.sv
// Stream bundle for the mantissa normaliser: upstream beat, downstream result and the underflow counter.
// master = the side that produces beats and consumes results; slave = the normaliser itself.
`default_nettype none

interface mant_normalize_pipe_if #(
    parameter int EXP_W = 5,
    parameter int UFC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       mant_in;
    logic [EXP_W-1:0] exp_in;
    logic [7:0]       lzc_in;

    logic             out_valid;
    logic             out_ready;
    logic [7:0]       mant_out;
    logic [EXP_W-1:0] exp_out;
    logic             zero_out;
    logic             uf_out;

    logic [UFC_W-1:0] uf_count;
    logic             uf_clr;

    modport master (
        output in_valid, mant_in, exp_in, lzc_in, out_ready, uf_clr,
        input  in_ready, out_valid, mant_out, exp_out, zero_out, uf_out, uf_count
    );

    modport slave (
        input  in_valid, mant_in, exp_in, lzc_in, out_ready, uf_clr,
        output in_ready, out_valid, mant_out, exp_out, zero_out, uf_out, uf_count
    );
endinterface

`default_nettype wire

// File: rtl/mant_normalize_pipe.sv
// Left-normalises a mantissa by the LZC shift, adjusts the exponent, clamps underflow at 0 and counts clamps.
// Two registered stages, 2-cycle latency, 1 beat/cycle; combinational ready chain stalls S1/S2 under backpressure.
`default_nettype none

module mant_normalize_pipe #(
    parameter int EXP_W = 5,
    parameter int UFC_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mant_normalize_pipe_if.slave  bus
);

    typedef struct packed {
        logic [7:0]       mant;
        logic [EXP_W-1:0] exp;
        logic [2:0]       sh;
    } s1_t;

    typedef struct packed {
        logic [7:0]       mant;
        logic [EXP_W-1:0] exp;
        logic             zero;
        logic             uf;
    } res_t;

    logic             s1_valid_q;
    logic             s1_valid_d;
    s1_t              s1_q;
    s1_t              s1_d;

    logic             s2_valid_q;
    logic             s2_valid_d;
    res_t             s2_q;
    res_t             s2_d;

    logic [UFC_W-1:0] uf_cnt_q;
    logic [UFC_W-1:0] uf_cnt_d;

    logic             s1_adv;
    logic             s2_adv;
    logic             in_fire;
    logic             s2_load;
    res_t             calc;
    logic [EXP_W-1:0] sh_ext;
    logic             lzc_hi_unused;

    // Only the low three LZC bits carry the count; the rest is intentionally dropped.
    assign lzc_hi_unused = ^bus.lzc_in[7:3];

    always_comb begin
        s2_adv  = !s2_valid_q || bus.out_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        in_fire = bus.in_valid && s1_adv;
        s2_load = s2_adv && s1_valid_q;
    end

    // exp <= sh implies exp < 8, so exp[2:0] is the full clamped shift amount.
    always_comb begin
        calc   = '0;
        sh_ext = {{(EXP_W-3){1'b0}}, s1_q.sh};
        if (s1_q.mant == 8'h00) begin
            calc.zero = 1'b1;
        end else if (s1_q.exp > sh_ext) begin
            calc.mant = s1_q.mant << s1_q.sh;
            calc.exp  = s1_q.exp - sh_ext;
        end else begin
            calc.mant = s1_q.mant << s1_q.exp[2:0];
            calc.uf   = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
        end
        if (in_fire) begin
            s1_d.mant = bus.mant_in;
            s1_d.exp  = bus.exp_in;
            s1_d.sh   = bus.lzc_in[2:0];
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            s2_d = calc;
        end
    end

    // Clear wins over a same-cycle increment.
    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (bus.uf_clr) begin
            uf_cnt_d = '0;
        end else if (s2_load && calc.uf && (uf_cnt_q != {UFC_W{1'b1}})) begin
            uf_cnt_d = uf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
            uf_cnt_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
            uf_cnt_q   <= uf_cnt_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.mant_out  = s2_q.mant;
    assign bus.exp_out   = s2_q.exp;
    assign bus.zero_out  = s2_q.zero;
    assign bus.uf_out    = s2_q.uf;
    assign bus.uf_count  = uf_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mant_normalize_pipe.sv
// Directed and random bench for mant_normalize_pipe with a queue-based arithmetic reference model.
`default_nettype none

module tb_mant_normalize_pipe;
    localparam int EXP_W   = 5;
    localparam int UFC_W   = 8;
    localparam int UF_MAX  = (1 << UFC_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mant_normalize_pipe_if #(.EXP_W(EXP_W), .UFC_W(UFC_W)) bus ();

    mant_normalize_pipe #(.EXP_W(EXP_W), .UFC_W(UFC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]       m;
        logic [EXP_W-1:0] e;
        logic             z;
        logic             u;
    } beat_t;

    beat_t q[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    uf_acc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic beat_t model(input logic [7:0] m, input logic [EXP_W-1:0] e, input logic [7:0] l);
        beat_t r;
        int    sh;
        int    ev;
        int    prod;
        sh  = int'(l) % 8;
        ev  = int'(e);
        r.m = 8'h00;
        r.e = '0;
        r.z = 1'b0;
        r.u = 1'b0;
        if (m == 8'h00) begin
            r.z = 1'b1;
        end else if (ev > sh) begin
            prod = int'(m) * (2 ** sh);
            r.m  = prod[7:0];
            r.e  = EXP_W'(ev - sh);
        end else begin
            prod = int'(m) * (2 ** ev);
            r.m  = prod[7:0];
            r.u  = 1'b1;
        end
        return r;
    endfunction

    // One clock: sample handshakes just after the falling edge, score them, advance to the next falling edge.
    task automatic cycle(output bit in_fire, output bit out_fire);
        beat_t b;
        #1;
        in_fire  = bus.in_valid && bus.in_ready && rst_n;
        out_fire = bus.out_valid && bus.out_ready && rst_n;
        if (out_fire) begin
            chk("out_beat_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                b = q.pop_front();
                chk("out_mant", 32'(bus.mant_out), 32'(b.m));
                chk("out_exp",  32'(bus.exp_out),  32'(b.e));
                chk("out_zero", 32'(bus.zero_out), 32'(b.z));
                chk("out_uf",   32'(bus.uf_out),   32'(b.u));
            end
        end
        if (in_fire) begin
            b = model(bus.mant_in, bus.exp_in, bus.lzc_in);
            q.push_back(b);
            if (b.u && uf_acc < UF_MAX) uf_acc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] m, input logic [EXP_W-1:0] e, input logic [7:0] l);
        bit fi = 1'b0;
        bit fo;
        int n  = 0;
        bus.in_valid = 1'b1;
        bus.mant_in  = m;
        bus.exp_in   = e;
        bus.lzc_in   = l;
        while (!fi && n < 50) begin
            cycle(fi, fo);
            n++;
        end
        chk("send_accepted", 32'(fi), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit fi;
        bit fo;
        int n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (q.size() > 0 && n < 50) begin
            cycle(fi, fo);
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic directed(input logic [7:0] m, input logic [EXP_W-1:0] e, input logic [7:0] l,
                            input logic [7:0] em, input logic [EXP_W-1:0] ee, input bit ez, input bit eu);
        bit fi;
        bit fo;
        bus.out_ready = 1'b1;
        send(m, e, l);
        bus.out_ready = 1'b0;
        cycle(fi, fo);
        chk("lat2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("dir_mant",       32'(bus.mant_out),  32'(em));
        chk("dir_exp",        32'(bus.exp_out),   32'(ee));
        chk("dir_zero",       32'(bus.zero_out),  32'(ez));
        chk("dir_uf",         32'(bus.uf_out),    32'(eu));
        drain();
        chk("dir_uf_count",   32'(bus.uf_count),  32'(uf_acc));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit          fi;
        bit          fo;
        int          idx;
        int          n;
        logic [7:0]  held_m;
        logic [7:0]  bp_m [4];
        int          sh;

        bus.in_valid  = 1'b0;
        bus.mant_in   = 8'h00;
        bus.exp_in    = '0;
        bus.lzc_in    = 8'h00;
        bus.out_ready = 1'b0;
        bus.uf_clr    = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) cycle(fi, fo);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mant_out",  32'(bus.mant_out),  32'd0);
        chk("rst_exp_out",   32'(bus.exp_out),   32'd0);
        chk("rst_zero_out",  32'(bus.zero_out),  32'd0);
        chk("rst_uf_out",    32'(bus.uf_out),    32'd0);
        chk("rst_uf_count",  32'(bus.uf_count),  32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);

        // Directed arithmetic cases
        directed(8'h13, 5'd10, 8'h03, 8'h98, 5'd7, 1'b0, 1'b0);
        directed(8'h00, 5'd9,  8'h07, 8'h00, 5'd0, 1'b1, 1'b0);
        directed(8'h05, 5'd3,  8'h05, 8'h28, 5'd0, 1'b0, 1'b1);
        chk("uf_count_after_first_uf", 32'(bus.uf_count), 32'd1);
        directed(8'h01, 5'd7,  8'h07, 8'h80, 5'd0, 1'b0, 1'b1);
        directed(8'h01, 5'd8,  8'h07, 8'h80, 5'd1, 1'b0, 1'b0);
        directed(8'h81, 5'd20, 8'hF9, 8'h02, 5'd19, 1'b0, 1'b0);

        // Backpressure: four beats streamed into a stalled output
        bp_m[0] = 8'h11; bp_m[1] = 8'h22; bp_m[2] = 8'h33; bp_m[3] = 8'h44;
        bus.out_ready = 1'b0;
        idx    = 0;
        held_m = 8'h00;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (idx < 4);
            bus.mant_in  = bp_m[idx % 4];
            bus.exp_in   = 5'd12;
            bus.lzc_in   = 8'h01;
            cycle(fi, fo);
            if (fi) idx++;
            if (c >= 1) begin
                chk("bp_in_ready_low", 32'(bus.in_ready),  32'd0);
                chk("bp_out_valid",    32'(bus.out_valid), 32'd1);
                if (c == 1) held_m = bus.mant_out;
                else        chk("bp_mant_stable", 32'(bus.mant_out), 32'(held_m));
            end
        end
        chk("bp_accepted_two", 32'(idx), 32'd2);
        bus.out_ready = 1'b1;
        n = 0;
        while ((idx < 4 || q.size() > 0) && n < 20) begin
            bus.in_valid = (idx < 4);
            bus.mant_in  = bp_m[idx % 4];
            cycle(fi, fo);
            if (fi) idx++;
            chk("bp_one_per_cycle", 32'(fo), 32'd1);
            n++;
        end
        chk("bp_release_cycles", 32'(n), 32'd4);
        bus.in_valid = 1'b0;

        // Saturation: 300 underflow beats back to back
        idx = 0;
        n   = 0;
        bus.out_ready = 1'b1;
        while (idx < 300 && n < 400) begin
            sh = $urandom_range(0, 7);
            bus.in_valid = 1'b1;
            bus.mant_in  = 8'($urandom_range(1, 255));
            bus.exp_in   = EXP_W'($urandom_range(0, sh));
            bus.lzc_in   = {5'($urandom_range(0, 31)), 3'(sh)};
            cycle(fi, fo);
            if (fi) idx++;
            n++;
        end
        chk("sat_sent", 32'(idx), 32'd300);
        drain();
        chk("sat_uf_count", 32'(bus.uf_count), 32'd255);
        chk("sat_uf_model", 32'(bus.uf_count), 32'(uf_acc));

        // Clear takes priority over the increment from a beat landing in S2 the same cycle
        send(8'h01, 5'd2, 8'h06);
        bus.uf_clr = 1'b1;
        cycle(fi, fo);
        bus.uf_clr = 1'b0;
        uf_acc = 0;
        chk("clr_uf_out",   32'(bus.uf_out),   32'd1);
        chk("clr_uf_count", 32'(bus.uf_count), 32'd0);
        drain();
        chk("clr_uf_count_hold", 32'(bus.uf_count), 32'd0);

        // Random traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.mant_in   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            bus.exp_in    = EXP_W'($urandom_range(0, 31));
            bus.lzc_in    = 8'($urandom_range(0, 255));
            cycle(fi, fo);
        end
        drain();
        chk("rand_uf_count", 32'(bus.uf_count), 32'(uf_acc));

        // Reset with both stages full
        bus.out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            bus.in_valid = 1'b1;
            bus.mant_in  = 8'h5A + 8'(c);
            bus.exp_in   = 5'd1;
            bus.lzc_in   = 8'h04;
            cycle(fi, fo);
        end
        bus.in_valid = 1'b0;
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_in_ready",  32'(bus.in_ready),  32'd0);
        rst_n = 1'b0;
        cycle(fi, fo);
        rst_n = 1'b1;
        q.delete();
        uf_acc = 0;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_uf_count",  32'(bus.uf_count),  32'd0);
        chk("midrst_mant_out",  32'(bus.mant_out),  32'd0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle(fi, fo);
            chk("midrst_no_stale", 32'(bus.out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
